// File: rtl/rsr_tx_sequencer.sv
// rsr_tx_sequencer
//   Sequences an external parallel-load right-shift register so that words
//   handed over a valid/ready handshake leave it LSB-first on its SO pin.
//   A one-entry holding buffer decouples the producer from the frame timing.
//   Each frame is BITS shift cycles long, followed by GAP idle cycles.
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RST          asynchronous active-low reset
//   in_data      word to serialize
//   in_valid     producer offers in_data
//   in_ready     holding buffer empty; word taken on in_valid && in_ready
//   abort        end the frame currently on SO (ignored outside SHIFT)
//   rsr_data     holding-buffer contents, wired to the register's data input
//   rsr_load     wired to the register's Load input
//   rsr_in       wired to the register's serial-in input; constant FILL
//   ser_valid    SO carries a frame bit in this cycle
//   ser_first    SO carries bit 0 of the frame
//   ser_last     SO carries bit BITS-1 of the frame
//   busy         a frame or gap is in progress, or a word is buffered
//   frame_count  completed, non-aborted frames (wraps at 2^16)

module rsr_tx_sequencer #(
  parameter int   BITS = 8,
  parameter int   GAP  = 2,
  parameter logic FILL = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            abort,
  output logic [BITS-1:0] rsr_data,
  output logic            rsr_load,
  output logic            rsr_in,
  output logic            ser_valid,
  output logic            ser_first,
  output logic            ser_last,
  output logic            busy,
  output logic [15:0]     frame_count
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BITS - 1);
  // GAP state is unreachable when GAP == 0; the clamp only keeps the constant legal.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            buf_full;
  logic [BITS-1:0] buf_data;
  logic            accept;
  logic            last_bit;
  logic            load;

  assign accept   = in_valid && !buf_full;
  assign last_bit = (bit_cnt == BIT_LAST);

  // The register samples Load at the end of the cycle, so the load decision
  // must see abort in the same cycle: a frame aborted on its last bit must
  // not chain straight into the buffered word.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves load unassigned (no latch).
    load = 1'b0;
    unique case (state)
      S_IDLE:  load = buf_full;
      S_SHIFT: load = (GAP == 0) && last_bit && !abort && buf_full;
      S_GAP:   load = (gap_cnt == GAP_LAST) && buf_full;
      default: load = 1'b0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
      frame_count <= '0;
    end else begin
      // Accept and load are mutually exclusive: accept needs the buffer
      // empty, load needs it full.
      if (accept) begin
        buf_full <= 1'b1;
        buf_data <= in_data;
      end else if (load) begin
        buf_full <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (load) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
          end
        end

        S_SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (abort) begin
            state   <= (GAP > 0) ? S_GAP : S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end else if (last_bit) begin
            frame_count <= frame_count + 16'd1;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            if (GAP > 0) begin
              state <= S_GAP;
            end else if (load) begin
              state <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state   <= load ? S_SHIFT : S_IDLE;
            bit_cnt <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output below decodes registers only, except rsr_load (see above).
  assign in_ready  = !buf_full;
  assign rsr_data  = buf_data;
  assign rsr_load  = load;
  assign rsr_in    = FILL;
  assign ser_valid = (state == S_SHIFT);
  assign ser_first = (state == S_SHIFT) && (bit_cnt == '0);
  assign ser_last  = (state == S_SHIFT) && last_bit;
  assign busy      = (state != S_IDLE) || buf_full;

endmodule

// File: tb/tb_rsr_tx_sequencer.sv
// tb_rsr_tx_sequencer
//   Directed bench for rsr_tx_sequencer. Instance dut_a runs with GAP=2,
//   dut_b with GAP=0; both drive a small behavioural model of the external
//   right-shift register so the serial stream itself can be checked.
//   Every cycle's outputs are sampled on the falling edge into a trace, and
//   each scenario then compares trace entries against hand-computed values.

module tb_rsr_tx_sequencer;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  // ---------------- instance A: GAP = 2 ----------------
  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_ready, a_abort;
  logic [7:0]  a_rsr_data;
  logic        a_rsr_load, a_rsr_in, a_ser_valid, a_ser_first, a_ser_last, a_busy;
  logic [15:0] a_frame_count;

  rsr_tx_sequencer #(.BITS(8), .GAP(2), .FILL(1'b1)) dut_a (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (a_in_data),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .abort      (a_abort),
    .rsr_data   (a_rsr_data),
    .rsr_load   (a_rsr_load),
    .rsr_in     (a_rsr_in),
    .ser_valid  (a_ser_valid),
    .ser_first  (a_ser_first),
    .ser_last   (a_ser_last),
    .busy       (a_busy),
    .frame_count(a_frame_count)
  );

  // ---------------- instance B: GAP = 0 ----------------
  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready, b_abort;
  logic [7:0]  b_rsr_data;
  logic        b_rsr_load, b_rsr_in, b_ser_valid, b_ser_first, b_ser_last, b_busy;
  logic [15:0] b_frame_count;

  rsr_tx_sequencer #(.BITS(8), .GAP(0), .FILL(1'b1)) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (b_in_data),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .abort      (b_abort),
    .rsr_data   (b_rsr_data),
    .rsr_load   (b_rsr_load),
    .rsr_in     (b_rsr_in),
    .ser_valid  (b_ser_valid),
    .ser_first  (b_ser_first),
    .ser_last   (b_ser_last),
    .busy       (b_busy),
    .frame_count(b_frame_count)
  );

  // ---------------- external shift-register models ----------------
  logic [7:0] a_sr = 8'hFF;
  logic [7:0] b_sr = 8'hFF;

  always @(posedge CLK) a_sr <= a_rsr_load ? a_rsr_data : {a_rsr_in, a_sr[7:1]};
  always @(posedge CLK) b_sr <= b_rsr_load ? b_rsr_data : {b_rsr_in, b_sr[7:1]};

  // ---------------- per-cycle trace ----------------
  typedef struct packed {
    logic        valid;
    logic        first;
    logic        last;
    logic        so;
    logic        load;
    logic        ready;
    logic        busy;
    logic [7:0]  data;
    logic [15:0] fc;
  } smp_t;

  localparam int TLEN = 512;
  smp_t ta [0:TLEN-1];
  smp_t tb [0:TLEN-1];
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (cyc < TLEN) begin
      ta[cyc] <= '{valid: a_ser_valid, first: a_ser_first, last: a_ser_last, so: a_sr[0],
                   load: a_rsr_load, ready: a_in_ready, busy: a_busy, data: a_rsr_data,
                   fc: a_frame_count};
      tb[cyc] <= '{valid: b_ser_valid, first: b_ser_first, last: b_ser_last, so: b_sr[0],
                   load: b_rsr_load, ready: b_in_ready, busy: b_busy, data: b_rsr_data,
                   fc: b_frame_count};
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Frame check on A: word w shifted out over cycles s..s+7.
  task automatic check_frame_a(input string tag, input int s, input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_valid%0d", tag, k), ta[s+k].valid, 1'b1);
      check($sformatf("%s_so%0d", tag, k), ta[s+k].so, w[k]);
      check($sformatf("%s_first%0d", tag, k), ta[s+k].first, (k == 0));
      check($sformatf("%s_last%0d", tag, k), ta[s+k].last, (k == 7));
    end
  endtask

  int c;
  int run;

  initial begin
    RST = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h33; a_abort = 1'b0;
    b_in_valid = 1'b1; b_in_data = 8'h33; b_abort = 1'b0;

    // ---------- T1: reset with in_valid held high ----------
    step(); step();
    c = cyc;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    step();
    RST = 1'b1;
    repeat (3) step();
    check("rst_ready",  ta[c-1].ready, 1'b1);
    check("rst_load",   ta[c-1].load,  1'b0);
    check("rst_valid",  ta[c-1].valid, 1'b0);
    check("rst_busy",   ta[c-1].busy,  1'b0);
    check("rst_fc",     ta[c-1].fc,    16'd0);
    check("rst_data",   ta[c-1].data,  8'h00);
    check("rst_b_busy", tb[c-1].busy,  1'b0);
    check("post_rst_busy",  ta[c+2].busy,  1'b0);
    check("post_rst_ready", ta[c+2].ready, 1'b1);

    // ---------- T2: single word 0xA5 on A ----------
    a_in_valid = 1'b1; a_in_data = 8'hA5;
    c = cyc;
    step();
    a_in_valid = 1'b0;
    repeat (14) step();
    check("t2_ready_c",  ta[c].ready,  1'b1);
    check("t2_load",     ta[c+1].load, 1'b1);
    check("t2_data",     ta[c+1].data, 8'hA5);
    check("t2_valid_c1", ta[c+1].valid, 1'b0);
    check_frame_a("t2", c + 2, 8'hA5);
    check("t2_valid_c10", ta[c+10].valid, 1'b0);
    check("t2_fc_c9",     ta[c+9].fc,  16'd0);
    check("t2_fc_c10",    ta[c+10].fc, 16'd1);
    check("t2_busy_c11",  ta[c+11].busy, 1'b1);
    check("t2_busy_c12",  ta[c+12].busy, 1'b0);
    check("t2_idle_so",   ta[c+11].so, 1'b1);

    // ---------- T3: gapped stream 0x0F, 0xF0 on A ----------
    a_in_valid = 1'b1; a_in_data = 8'h0F;
    c = cyc;
    step();
    a_in_data = 8'hF0;
    step(); step();
    a_in_valid = 1'b0;
    repeat (19) step();
    check("t3_ready_c1", ta[c+1].ready, 1'b0);
    check_frame_a("t3a", c + 2, 8'h0F);
    check("t3_gap0",   ta[c+10].valid, 1'b0);
    check("t3_gap1",   ta[c+11].valid, 1'b0);
    check("t3_load_g0", ta[c+10].load, 1'b0);
    check("t3_load_g1", ta[c+11].load, 1'b1);
    check_frame_a("t3b", c + 12, 8'hF0);
    check("t3_fc", ta[c+20].fc, 16'd3);

    // ---------- T4: back-to-back 0x0F, 0xF0 on B ----------
    b_in_valid = 1'b1; b_in_data = 8'h0F;
    c = cyc;
    step();
    b_in_data = 8'hF0;
    step(); step();
    b_in_valid = 1'b0;
    repeat (18) step();
    run = 0;
    for (int i = c + 2; i <= c + 17; i++) run += int'(tb[i].valid);
    check("t4_run16",     run, 16);
    check("t4_valid_pre", tb[c+1].valid,  1'b0);
    check("t4_valid_post", tb[c+18].valid, 1'b0);
    check("t4_last1",     tb[c+9].last,  1'b1);
    check("t4_load_last", tb[c+9].load,  1'b1);
    check("t4_first2",    tb[c+10].first, 1'b1);
    check("t4_so_f1b0",   tb[c+2].so,  1'b1);
    check("t4_so_f2b0",   tb[c+10].so, 1'b0);
    check("t4_so_f2b4",   tb[c+14].so, 1'b1);
    check("t4_fc_mid",    tb[c+10].fc, 16'd1);
    check("t4_fc",        tb[c+18].fc, 16'd2);

    // ---------- T5: backpressure and abort on bit 3 (A) ----------
    a_in_valid = 1'b1; a_in_data = 8'h3C;
    c = cyc;
    step();
    a_in_data = 8'h99;
    step(); step(); step(); step();    // now in cycle c+5, bit 3 on SO
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    a_in_valid = 1'b0;
    repeat (12) step();
    check("t5_ready_full", ta[c+3].ready, 1'b0);
    for (int i = c + 3; i <= c + 7; i++)
      check($sformatf("t5_data_stable%0d", i - c), ta[i].data, 8'h99);
    check("t5_abort_valid", ta[c+5].valid, 1'b1);
    check("t5_abort_so",    ta[c+5].so,    1'b1);
    check("t5_after_abort", ta[c+6].valid, 1'b0);
    check("t5_load_gap0",   ta[c+6].load,  1'b0);
    check("t5_load_gap1",   ta[c+7].load,  1'b1);
    check("t5_fc_kept",     ta[c+7].fc,    16'd3);
    check_frame_a("t5b", c + 8, 8'h99);
    check("t5_fc", ta[c+16].fc, 16'd4);

    // ---------- T6: abort on the last bit with a word buffered (B) ----------
    b_in_valid = 1'b1; b_in_data = 8'h55;
    c = cyc;
    step();
    b_in_data = 8'hAA;
    step(); step();
    b_in_valid = 1'b0;
    repeat (6) step();                 // now in cycle c+9, last bit
    b_abort = 1'b1;
    step();
    b_abort = 1'b0;
    repeat (11) step();
    check("t6_last",       tb[c+9].last,   1'b1);
    check("t6_noload",     tb[c+9].load,   1'b0);
    check("t6_idle_valid", tb[c+10].valid, 1'b0);
    check("t6_idle_load",  tb[c+10].load,  1'b1);
    check("t6_fc_kept",    tb[c+10].fc,    16'd2);
    check("t6_first",      tb[c+11].first, 1'b1);
    check("t6_so_b0",      tb[c+11].so,    1'b0);
    check("t6_so_b1",      tb[c+12].so,    1'b1);
    check("t6_fc",         tb[c+19].fc,    16'd3);

    // ---------- T7: reset in the middle of a frame (A) ----------
    a_in_valid = 1'b1; a_in_data = 8'h5A;
    c = cyc;
    step();
    a_in_data = 8'hC3;
    step(); step();
    a_in_valid = 1'b0;
    repeat (4) step();                 // now in cycle c+7, bit 5 on SO
    RST = 1'b0;
    step(); step();
    RST = 1'b1;
    step(); step(); step();            // cycles c+9..c+11 idle
    a_in_valid = 1'b1; a_in_data = 8'h81;
    step();
    a_in_valid = 1'b0;
    repeat (12) step();
    check("t7_pre_valid", ta[c+6].valid, 1'b1);
    check("t7_rst_ready", ta[c+7].ready, 1'b1);
    check("t7_rst_load",  ta[c+7].load,  1'b0);
    check("t7_rst_valid", ta[c+7].valid, 1'b0);
    check("t7_rst_first", ta[c+7].first, 1'b0);
    check("t7_rst_last",  ta[c+7].last,  1'b0);
    check("t7_rst_busy",  ta[c+7].busy,  1'b0);
    check("t7_rst_fc",    ta[c+7].fc,    16'd0);
    check("t7_rst_data",  ta[c+7].data,  8'h00);
    for (int i = c + 9; i <= c + 11; i++) begin
      check($sformatf("t7_quiet_valid%0d", i - c), ta[i].valid, 1'b0);
      check($sformatf("t7_quiet_busy%0d", i - c),  ta[i].busy,  1'b0);
    end
    check("t7_load",  ta[c+13].load, 1'b1);
    check_frame_a("t7", c + 14, 8'h81);
    check("t7_fc", ta[c+22].fc, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rsr_tx_sequencer.md
Name: rsr_tx_sequencer

Overview:
- Controller that sequences an external parallel-load right-shift register (Parallel_RSR) to serialize words onto a one-bit stream.
- Accepts words over a valid/ready handshake into a one-entry holding buffer.
- Drives the register's Load, data and fill-bit inputs, counts shifted bits, inserts a programmable inter-frame gap and flags which cycles of the register's SO output carry valid data.
- Sits between a word producer and the shift register; downstream logic qualifies SO with ser_valid.

Parameters:
- BITS, 8, word width; also the number of shift cycles per frame (≥2).
- GAP, 2, ser_valid-low cycles inserted between consecutive frames (0 = back-to-back).
- FILL, 1'b1, constant fill bit driven on rsr_in (idle line level).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low (RST=0 resets).
- in_data  input  BITS  word to serialize.
- in_valid  input  1  producer has a word.
- in_ready  output  1  buffer empty; word accepted on in_valid&&in_ready at a rising edge.
- abort  input  1  terminate the frame currently shifting.
- rsr_data  output  BITS  holding-buffer contents, to RSR data.
- rsr_load  output  1  to RSR Load.
- rsr_in  output  1  to RSR In; constant FILL.
- ser_valid  output  1  RSR SO carries a frame bit this cycle.
- ser_first  output  1  bit 0 of frame on SO.
- ser_last  output  1  bit BITS-1 of frame on SO.
- busy  output  1  state!=IDLE or buffer full.
- frame_count  output  16  completed (non-aborted) frames, wraps at 2^16.

Behaviour:
- RSR contract: a Load sampled at an edge makes SO = data[0] in the next cycle; each later edge shifts right, so SO = data[k] k cycles later.
- Reset (async, RST=0): state=IDLE, buffer empty, bit_cnt=0, frame_count=0, gap_cnt=0. Outputs: in_ready=1, rsr_load=0, ser_valid/first/last=0, busy=0, rsr_data=0.
- Reset mid-frame discards the frame and the buffered word. No partial-frame flags after release.
- in_ready = !buf_full, registered only; there is no combinational path from rsr_load.
- Buffer fills on handshake and empties on the edge where rsr_load=1.
- rsr_data is held stable while the buffer is full.
- States IDLE, SHIFT, GAP.
- IDLE: rsr_load = buf_full. On load, go to SHIFT with bit_cnt=0.
- SHIFT: ser_valid=1; ser_first=(bit_cnt==0); ser_last=(bit_cnt==BITS-1); bit_cnt increments each cycle.
- On the last bit: frame_count++.
  - GAP>0: go to GAP, gap_cnt=0.
  - GAP=0 and buf_full: rsr_load=1 in this same cycle and stay in SHIFT with bit_cnt=0, giving a continuous stream.
  - GAP=0 and buffer empty: go to IDLE.
- GAP: ser_valid=0 for exactly GAP cycles.
  - In the final GAP cycle, if buf_full, rsr_load=1 and go to SHIFT; otherwise go to IDLE.
- abort in SHIFT: the current cycle's flags stay valid, frame_count is not incremented, and the next state is GAP (GAP>0) or IDLE (GAP=0). No load occurs in the abort cycle, and the buffered word is retained and sent later. abort outside SHIFT is ignored.
- abort coinciding with the last bit: abort wins; the frame is not counted.
- Latency: handshake at cycle c gives rsr_load at c+1 (from IDLE), first bit c+2, last bit c+BITS+1, frame_count updated at c+BITS+2.
- After an unreloaded frame the register drains FILL bits, so the line idles at FILL.

Test Plan:
- Reset: drive RST=0 with in_valid=1 → in_ready=1, rsr_load=0, ser_valid=0, busy=0, frame_count=0; no word accepted.
- Single word (BITS=8, GAP=2): 8'hA5 handshake at c → rsr_load=1 and rsr_data=A5 at c+1; SO 1,0,1,0,0,1,0,1 with ser_valid over c+2..c+9; ser_first at c+2; ser_last at c+9; frame_count=1 at c+10; busy=0 at c+12.
- Gapped stream (GAP=2): 0x0F then 0xF0 offered early → ser_valid low exactly 2 cycles between frames; rsr_load in the 2nd gap cycle; frame_count=2.
- Back-to-back (GAP=0): 0x0F, 0xF0 → ser_valid high 16 consecutive cycles; rsr_load coincides with ser_last of frame 1.
- Backpressure and abort: in_valid held with buffer full → in_ready=0 and rsr_data stable; abort on bit 3 → ser_valid=0 next cycle, frame_count unchanged, buffered word sent after GAP.
- Reset mid-frame: RST=0 at bit 5 → all outputs at reset values immediately; buffered word dropped; after release, a fresh word serializes normally.
